pipe_sched: RTL and testbench
=============================

Name: pipe_sched

Overview:
- Central pipeline scheduler for the 5-stage core.
- Merges stall requests from ID, EX and MEM, and sequences the multi-cycle divider.
- Arbitrates the PC write sources (exception, ERET, EX-stage branch) into the single `pcwr_en`/`address` pair consumed by the PC register.
- Drives the 6-bit stall vector and the flush controls for every pipeline register.

Parameters:
DIV_CYCLES, 32, EX cycles held per divide (1..63)
EXC_VECTOR, 32'h0000_0020, PC loaded on any exception

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
stallreq_id_i  in  1  ID hazard (load-use) request
stallreq_mem_i  in  1  MEM wait (bus not ready)
div_start_i  in  1  EX holds a divide; pulse or level while EX holds it
div_done_o  out  1  one-cycle pulse: divide result valid
br_taken_i  in  1  EX-stage taken branch/jump
br_target_i  in  32  branch target
exc_i  in  1  MEM-stage exception
exc_pc_i  in  32  PC of faulting instruction
eret_i  in  1  MEM-stage ERET
stall_o  out  6  [5]=PC [4]=IF/ID [3]=ID/EX [2]=EX/MEM [1]=MEM/WB [0]=WB, 1=hold
flush_o  out  1  clear IF/ID, ID/EX, EX/MEM
flush_ifid_o  out  1  clear IF/ID only
pcwr_en_o  out  1  load PC with address_o
address_o  out  32  PC load value
epc_o  out  32  saved exception PC

Behaviour:
- **Reset values:**
  - state=IDLE, div_cnt=0, epc_o=0.
  - All outputs 0.
  - Reset mid-divide aborts the divide with no `div_done_o`.
- **Registered state:** state ∈ {IDLE, DIV_BUSY}, div_cnt[5:0], epc_o.
- **Outputs:** all other outputs are combinational from state and the current inputs.
- **Per-cycle priority (highest first):**
  1. `exc_i`:
     - pcwr_en_o=1, address_o=EXC_VECTOR, flush_o=1, stall_o=0.
     - epc_o <= exc_pc_i at the clock edge.
     - state->IDLE and div_cnt->0; the divide is aborted, no `div_done_o`.
     - Overrides all stalls, so the PC register sees stall[5]=0.
  2. `eret_i`:
     - pcwr_en_o=1, address_o=epc_o, flush_o=1, stall_o=0.
  3. `stallreq_mem_i`: stall_o=6'b111110, no redirect.
  4. EX busy, i.e. state==DIV_BUSY, or state==IDLE with div_start_i and not done:
     - stall_o=6'b111100.
     - br_taken_i is ignored; EX re-presents the branch after the stall.
  5. `br_taken_i`:
     - pcwr_en_o=1, address_o=br_target_i, flush_ifid_o=1, stall_o=0.
     - Overrides stallreq_id_i, because the ID instruction is wrong-path.
  6. `stallreq_id_i`: stall_o=6'b111000.
  7. Otherwise stall_o=0 and pcwr_en_o=0.
- **address_o:** 0 whenever pcwr_en_o=0.
- **Divider FSM:**
  - IDLE: div_start_i (no exc/eret/mem stall) -> DIV_BUSY, div_cnt<=DIV_CYCLES-1.
  - DIV_BUSY, div_cnt>0: div_cnt decrements each cycle; stall_o=6'b111100.
  - DIV_BUSY, div_cnt==0: div_done_o=1 and stall_o=0 this cycle; state->IDLE.
  - div_cnt decrements only when stallreq_mem_i=0. A MEM stall freezes the count and forces 6'b111110, so div_done_o never coincides with a MEM stall.
  - div_start_i seen in IDLE in the cycle right after div_done_o is the *same* instruction leaving EX. It must not restart: a 1-cycle done_seen flag suppresses it.
  - Total EX residency for a divide is DIV_CYCLES+1 cycles.
- **Arithmetic:**
  - div_cnt is 6 bits with no wrap; DIV_CYCLES ≤ 63.
- **Simultaneous events:**
  - exc_i with eret_i: exception wins.
  - Branch during a MEM stall: stall wins; EX holds the branch.

Test Plan:
- **Reset:**
  - Stimulus: rst_n low mid-divide (cnt=10), release, then idle.
  - Required: all outputs 0, state IDLE, no div_done_o ever.
- **Load-use:**
  - Stimulus: stallreq_id_i=1 for 1 cycle.
  - Required: stall_o=6'b111000 that cycle, then 0; pcwr_en_o=0.
- **Branch over ID stall:**
  - Stimulus: br_taken_i=1, br_target_i=32'h0000_0400, stallreq_id_i=1.
  - Required: pcwr_en_o=1, address_o=0x400, flush_ifid_o=1, stall_o=0.
- **Divide, DIV_CYCLES=4:**
  - Stimulus: div_start_i held.
  - Required:
    - stall_o=6'b111100 for 4 cycles.
    - Then div_done_o=1 with stall_o=0.
    - No restart on the following cycle.
    - Repeat with stallreq_mem_i asserted 2 cycles mid-divide: done is delayed by exactly 2 cycles.
- **Exception mid-divide:**
  - Stimulus: exc_i=1, exc_pc_i=0x1234 at div_cnt=2.
  - Required:
    - pcwr_en_o=1, address_o=0x20, flush_o=1, stall_o=0.
    - epc_o=0x1234 next cycle.
    - state IDLE, no div_done_o.
- **ERET and priority:**
  - Stimulus: eret_i=1 after the exception above.
  - Required: address_o=0x1234, flush_o=1.
  - Stimulus: exc_i=1 with eret_i=1.
  - Required: address_o=0x20.

Source files
------------

// File: rtl/pipe_sched.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_sched
//  Purpose  : Central pipeline scheduler for the 5-stage core. Merges ID/EX/MEM
//             stall requests, sequences the multi-cycle divider, arbitrates the
//             PC write sources (exception > ERET > EX branch) and drives the
//             per-register stall vector and flush controls.
//  Ports    : clk, rst_n          - clock, asynchronous active-low reset
//             stallreq_id_i       - ID load-use hazard
//             stallreq_mem_i      - MEM waiting on the bus
//             div_start_i         - EX holds a divide (pulse or level)
//             div_done_o          - one-cycle pulse, divide result valid
//             br_taken_i/_target_i- EX-stage taken branch and its target
//             exc_i/exc_pc_i      - MEM-stage exception and faulting PC
//             eret_i              - MEM-stage ERET
//             stall_o[5:0]        - [5]=PC .. [0]=WB, 1 = hold
//             flush_o             - clear IF/ID, ID/EX, EX/MEM
//             flush_ifid_o        - clear IF/ID only
//             pcwr_en_o/address_o - PC load strobe and value
//             epc_o               - saved exception PC
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_sched #(
  parameter int unsigned DIV_CYCLES = 32,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stallreq_id_i,
  input  logic        stallreq_mem_i,
  input  logic        div_start_i,
  output logic        div_done_o,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  input  logic        exc_i,
  input  logic [31:0] exc_pc_i,
  input  logic        eret_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic        flush_ifid_o,
  output logic        pcwr_en_o,
  output logic [31:0] address_o,
  output logic [31:0] epc_o
);

  typedef enum logic [0:0] {
    S_IDLE     = 1'b0,
    S_DIV_BUSY = 1'b1
  } state_t;

  // Counter load value: the start cycle itself is one of the DIV_CYCLES
  // stall cycles, so the busy phase counts down from DIV_CYCLES-1 to 0.
  localparam logic [5:0] C_DIV_LOAD = 6'(DIV_CYCLES - 1);

  localparam logic [5:0] C_STALL_MEM = 6'b111110;
  localparam logic [5:0] C_STALL_EX  = 6'b111100;
  localparam logic [5:0] C_STALL_ID  = 6'b111000;

  state_t      state_q, state_d;
  logic [5:0]  div_cnt_q, div_cnt_d;
  logic        done_seen_q, done_seen_d;
  logic [31:0] epc_q, epc_d;
  logic        ex_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      div_cnt_q   <= 6'd0;
      done_seen_q <= 1'b0;
      epc_q       <= 32'd0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      done_seen_q <= done_seen_d;
      epc_q       <= epc_d;
    end
  end

  // EX is busy while counting, or when a fresh divide appears in IDLE. The
  // done_seen flag masks the stale div_start of the instruction that just
  // finished and is still leaving EX.
  assign ex_busy = ((state_q == S_DIV_BUSY) && (div_cnt_q != 6'd0)) ||
                   ((state_q == S_IDLE) && div_start_i && !done_seen_q);

  always_comb begin
    state_d      = state_q;
    div_cnt_d    = div_cnt_q;
    done_seen_d  = 1'b0;
    epc_d        = epc_q;
    stall_o      = 6'b000000;
    flush_o      = 1'b0;
    flush_ifid_o = 1'b0;
    pcwr_en_o    = 1'b0;
    address_o    = 32'd0;
    div_done_o   = 1'b0;

    if (exc_i) begin
      pcwr_en_o = 1'b1;
      address_o = EXC_VECTOR;
      flush_o   = 1'b1;
      epc_d     = exc_pc_i;
      state_d   = S_IDLE;
      div_cnt_d = 6'd0;
    end else if (eret_i) begin
      // ERET flushes EX as well, so any divide in flight is dropped.
      pcwr_en_o = 1'b1;
      address_o = epc_q;
      flush_o   = 1'b1;
      state_d   = S_IDLE;
      div_cnt_d = 6'd0;
    end else if (stallreq_mem_i) begin
      // Divider progress is frozen; done can never coincide with this.
      stall_o = C_STALL_MEM;
    end else if (ex_busy) begin
      stall_o = C_STALL_EX;
      if (state_q == S_IDLE) begin
        state_d   = S_DIV_BUSY;
        div_cnt_d = C_DIV_LOAD;
      end else begin
        div_cnt_d = div_cnt_q - 6'd1;
      end
    end else begin
      if (state_q == S_DIV_BUSY) begin
        // Count exhausted: result valid, EX releases this cycle.
        div_done_o  = 1'b1;
        done_seen_d = 1'b1;
        state_d     = S_IDLE;
      end
      if (br_taken_i) begin
        // The ID instruction is wrong-path, so its hazard is irrelevant.
        pcwr_en_o    = 1'b1;
        address_o    = br_target_i;
        flush_ifid_o = 1'b1;
      end else if (stallreq_id_i) begin
        stall_o = C_STALL_ID;
      end
    end
  end

  assign epc_o = epc_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_sched
//  Purpose  : Self-checking bench for pipe_sched. Directed scenarios followed
//             by randomized traffic, all compared against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_sched;

  localparam int          N_DIV = 4;
  localparam logic [31:0] EXC_V = 32'h0000_0020;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stallreq_id_i, stallreq_mem_i, div_start_i, br_taken_i, exc_i, eret_i;
  logic [31:0] br_target_i, exc_pc_i;
  logic        div_done_o, flush_o, flush_ifid_o, pcwr_en_o;
  logic [5:0]  stall_o;
  logic [31:0] address_o, epc_o;

  int checks = 0;
  int errors = 0;

  pipe_sched #(.DIV_CYCLES(N_DIV), .EXC_VECTOR(EXC_V)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stallreq_id_i  (stallreq_id_i),
    .stallreq_mem_i (stallreq_mem_i),
    .div_start_i    (div_start_i),
    .div_done_o     (div_done_o),
    .br_taken_i     (br_taken_i),
    .br_target_i    (br_target_i),
    .exc_i          (exc_i),
    .exc_pc_i       (exc_pc_i),
    .eret_i         (eret_i),
    .stall_o        (stall_o),
    .flush_o        (flush_o),
    .flush_ifid_o   (flush_ifid_o),
    .pcwr_en_o      (pcwr_en_o),
    .address_o      (address_o),
    .epc_o          (epc_o)
  );

  always #5 clk = ~clk;

  // Behavioural model: a divide is "in flight" with a count of how many
  // productive EX cycles it has already used; it completes on the cycle after
  // it has used N_DIV of them.
  bit          m_active;
  int          m_used;
  bit          m_just_done;
  logic [31:0] m_epc;

  logic [5:0]  e_stall;
  logic        e_flush, e_flush_ifid, e_pcwr, e_done;
  logic [31:0] e_addr;

  task automatic model_reset();
    m_active = 0; m_used = 0; m_just_done = 0; m_epc = 32'd0;
  endtask

  task automatic model_eval();
    e_stall = 6'b0; e_flush = 0; e_flush_ifid = 0; e_pcwr = 0; e_done = 0; e_addr = 32'd0;
    if (exc_i) begin
      e_pcwr = 1; e_addr = EXC_V; e_flush = 1;
    end else if (eret_i) begin
      e_pcwr = 1; e_addr = m_epc; e_flush = 1;
    end else if (stallreq_mem_i) begin
      e_stall = 6'b111110;
    end else if ((m_active && m_used < N_DIV) || (!m_active && div_start_i && !m_just_done)) begin
      e_stall = 6'b111100;
    end else begin
      e_done = m_active;
      if (br_taken_i) begin
        e_pcwr = 1; e_addr = br_target_i; e_flush_ifid = 1;
      end else if (stallreq_id_i) begin
        e_stall = 6'b111000;
      end
    end
  endtask

  task automatic model_update();
    bit done_now;
    done_now = e_done;
    if (exc_i) begin
      m_epc = exc_pc_i; m_active = 0; m_used = 0;
    end else if (eret_i) begin
      m_active = 0; m_used = 0;
    end else if (stallreq_mem_i) begin
      // frozen
    end else if (m_active) begin
      if (m_used < N_DIV) m_used++;
      else begin m_active = 0; m_used = 0; end
    end else if (div_start_i && !m_just_done) begin
      m_active = 1; m_used = 1;
    end
    m_just_done = done_now;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("stall",      {26'd0, stall_o}, {26'd0, e_stall});
    chk("flush",      {31'd0, flush_o}, {31'd0, e_flush});
    chk("flush_ifid", {31'd0, flush_ifid_o}, {31'd0, e_flush_ifid});
    chk("pcwr_en",    {31'd0, pcwr_en_o}, {31'd0, e_pcwr});
    chk("address",    address_o, e_addr);
    chk("div_done",   {31'd0, div_done_o}, {31'd0, e_done});
    chk("epc",        epc_o, m_epc);
  endtask

  // One clock cycle: drive in the low phase, check, then advance the model.
  task automatic step(input logic exc, input logic [31:0] xpc, input logic eret,
                      input logic mem, input logic ds, input logic br,
                      input logic [31:0] bt, input logic id, output logic done_obs);
    @(negedge clk);
    exc_i = exc; exc_pc_i = xpc; eret_i = eret; stallreq_mem_i = mem;
    div_start_i = ds; br_taken_i = br; br_target_i = bt; stallreq_id_i = id;
    #1;
    model_eval();
    check_all();
    done_obs = div_done_o;
    @(posedge clk);
    model_update();
  endtask

  task automatic idle_inputs();
    exc_i = 0; exc_pc_i = 0; eret_i = 0; stallreq_mem_i = 0;
    div_start_i = 0; br_taken_i = 0; br_target_i = 0; stallreq_id_i = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_stall"},   {26'd0, stall_o}, 32'd0);
    chk({tag, "_pcwr"},    {31'd0, pcwr_en_o}, 32'd0);
    chk({tag, "_addr"},    address_o, 32'd0);
    chk({tag, "_flush"},   {30'd0, flush_o, flush_ifid_o}, 32'd0);
    chk({tag, "_done"},    {31'd0, div_done_o}, 32'd0);
    chk({tag, "_epc"},     epc_o, 32'd0);
  endtask

  logic d;
  int   lat;
  logic r_exc, r_eret, r_mem, r_ds, r_br, r_id;

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #2;
    check_reset_outputs("reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Load-use hazard for one cycle, then quiet.
    step(0, 0, 0, 0, 0, 0, 0, 1, d);
    chk("loaduse_stall", {26'd0, stall_o}, 32'h38);
    step(0, 0, 0, 0, 0, 0, 0, 0, d);

    // Branch wins over an ID hazard.
    step(0, 0, 0, 0, 0, 1, 32'h0000_0400, 1, d);
    chk("branch_addr", address_o, 32'h0000_0400);

    // Divide with div_start held: done after N_DIV stall cycles.
    lat = 0; d = 0;
    for (int k = 0; k < 20 && !d; k++) begin
      step(0, 0, 0, 0, 1, 0, 0, 0, d);
      lat++;
    end
    chk("div_latency", lat, N_DIV + 1);
    // Same instruction still presenting div_start: must not restart.
    step(0, 0, 0, 0, 1, 0, 0, 0, d);
    chk("div_no_restart", {26'd0, stall_o}, 32'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0, d);

    // Divide with a 2-cycle MEM stall in the middle: done 2 cycles later.
    lat = 0; d = 0;
    for (int k = 0; k < 20 && !d; k++) begin
      step(0, 0, 0, (k == 2 || k == 3), 1, 0, 0, 0, d);
      lat++;
    end
    chk("div_latency_mem", lat, N_DIV + 3);
    step(0, 0, 0, 0, 0, 0, 0, 0, d);

    // Exception mid-divide (count at 2), then ERET back to the saved PC.
    step(0, 0, 0, 0, 1, 0, 0, 0, d);
    step(0, 0, 0, 0, 1, 0, 0, 0, d);
    step(1, 32'h0000_1234, 0, 0, 1, 0, 0, 0, d);
    chk("exc_addr", address_o, EXC_V);
    lat = 0;
    for (int k = 0; k < 6; k++) begin
      step(0, 0, 0, 0, 0, 0, 0, 0, d);
      lat += int'(d);
    end
    chk("exc_epc", epc_o, 32'h0000_1234);
    chk("exc_no_done", lat, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0, d);
    chk("eret_addr", address_o, 32'h0000_1234);
    step(1, 32'h0000_5678, 1, 0, 0, 0, 0, 0, d);
    chk("exc_over_eret", address_o, EXC_V);

    // Asynchronous reset in the middle of a divide aborts it silently.
    step(0, 0, 0, 0, 1, 0, 0, 0, d);
    step(0, 0, 0, 0, 1, 0, 0, 0, d);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    for (int k = 0; k < 8; k++) begin
      step(0, 0, 0, 0, 0, 0, 0, 0, d);
      lat += int'(d);
    end
    chk("reset_no_done", lat, 0);

    // Randomized traffic with a level-style div_start.
    r_ds = 0;
    for (int i = 0; i < 600; i++) begin
      r_exc  = ($urandom_range(0, 24) == 0);
      r_eret = ($urandom_range(0, 24) == 0);
      r_mem  = ($urandom_range(0, 5) == 0);
      r_br   = ($urandom_range(0, 3) == 0);
      r_id   = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0) r_ds = ~r_ds;
      step(r_exc, $urandom, r_eret, r_mem, r_ds, r_br, $urandom, r_id, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
